// File: rtl/pr_dev_pkg.sv
// Shared definitions for processor-bus peripherals: register offsets,
// CTRL field positions, timer modes and the timer state encoding.
package pr_dev_pkg;

  // Word offsets within a device window, selected by byte address [3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Timer modes; encodings 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } timer_state_e;

  // Assemble the readable CTRL word; bits [31:4] always read as zero
  function automatic logic [31:0] ctrl_pack(input logic en,
                                            input logic [1:0] mode,
                                            input logic im);
    return {28'd0, im, mode, en};
  endfunction

endpackage

// File: rtl/pr_timer.sv
// Programmable down-counting timer on the processor device bus.
// Decodes a 16-byte window holding CTRL, PRESET and COUNT; raises a level
// interrupt in one-shot mode and a one-cycle pulse in auto-reload mode.
module pr_timer
  import pr_dev_pkg::*;
#(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        IOWrite,
  output logic [31:0] PrRD,
  output logic        hit,
  output logic        irq
);

  timer_state_e state_q, state_d;
  logic         en_q, en_d;
  logic [1:0]   mode_q, mode_d;
  logic         im_q, im_d;
  logic [31:0]  preset_q, preset_d;
  logic [31:0]  count_q, count_d;
  logic         pend_q, pend_d;

  logic [1:0]   reg_sel;
  logic         wr_en;
  logic         wr_ctrl;
  logic         wr_preset;
  logic         en_eff;
  logic [1:0]   mode_eff;
  logic [31:0]  rd_data;

  // PrAddr is the word address, so its low two bits pick the register
  assign reg_sel   = PrAddr[1:0];
  assign hit       = (PrAddr[29:2] == BASE[31:4]);
  assign wr_en     = hit & IOWrite;
  assign wr_ctrl   = wr_en & (reg_sel == REG_CTRL);
  assign wr_preset = wr_en & (reg_sel == REG_PRESET);

  // A CTRL write on this edge overrides EN/MODE for the FSM decision,
  // so clearing EN stops CNT at the same edge
  assign en_eff   = wr_ctrl ? PrWD[CTRL_EN_BIT] : en_q;
  assign mode_eff = wr_ctrl ? PrWD[CTRL_MODE_MSB:CTRL_MODE_LSB] : mode_q;

  // Interrupt: held PEND in one-shot, pulse while in INT for auto-reload
  assign irq = im_q & (pend_q | ((state_q == ST_INT) & (mode_q == MODE_RELOAD)));

  // Next-state: timer FSM first, then bus writes which take priority
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_d = ST_IDLE;
        end else if (count_q == 32'd0) begin
          state_d = ST_INT;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (en_eff && (mode_eff == MODE_RELOAD)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Bus writes win over the FSM for CTRL fields and always clear PEND
    case ({wr_ctrl, wr_preset})
      2'b10: begin
        en_d   = PrWD[CTRL_EN_BIT];
        mode_d = PrWD[CTRL_MODE_MSB:CTRL_MODE_LSB];
        im_d   = PrWD[CTRL_IM_BIT];
        pend_d = 1'b0;
      end
      2'b01: begin
        preset_d = PrWD;
        pend_d   = 1'b0;
      end
      default: begin
        pend_d = pend_d;
      end
    endcase
  end

  // Combinational read mux; zero whenever the window is not addressed
  always_comb begin
    rd_data = 32'd0;
    if (hit) begin
      case (reg_sel)
        REG_CTRL:   rd_data = ctrl_pack(en_q, mode_q, im_q);
        REG_PRESET: rd_data = preset_q;
        REG_COUNT:  rd_data = count_q;
        default:    rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  assign PrRD = rd_data;

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= MODE_ONESHOT;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

endmodule

// File: tb/tb_pr_timer.sv
// Scoreboard bench for pr_timer: stimulus queues expected values, a
// monitor process samples the DUT outputs and compares.
`timescale 1ns/1ps
module tb_pr_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_HIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [29:0] PrAddr;
  logic [31:0] PrWD;
  logic        IOWrite;
  logic [31:0] PrRD;
  logic        hit;
  logic        irq;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  pr_timer #(.BASE(32'h0000_7F00)) dut (
    .clk     (clk),
    .rst     (rst),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .IOWrite (IOWrite),
    .PrRD    (PrRD),
    .hit     (hit),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  // Queue an expectation, present the address, then hand off to the monitor
  task automatic chk(input int kind, input logic [31:0] addr,
                     input logic [31:0] exp, input string name);
    exp_t e;
    logic [31:0] a;
    a = addr;
    if (kind != K_IRQ) PrAddr = a[31:2];
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    chk(K_RD, addr, exp, name);
  endtask

  task automatic irqc(input logic exp, input string name);
    chk(K_IRQ, 32'd0, {31'd0, exp}, name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] a;
    a = addr;
    PrAddr  = a[31:2];
    PrWD    = data;
    IOWrite = 1'b1;
    @(posedge clk);
    #1;
    IOWrite = 1'b0;
    PrWD    = 32'd0;
  endtask

  // Expected COUNT in auto-reload test: c edges after CTRL write, PRESET=3
  function automatic logic [31:0] reload_cnt(input int c);
    int p;
    if (c < 2) return 32'd0;
    p = (c - 2) % 6;
    if (p <= 3) return 32'(3 - p);
    return 32'd0;
  endfunction

  // Monitor: pop the oldest expectation and compare with the DUT output
  initial begin : monitor
    exp_t e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL monitor: sample with no queued expectation");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_RD:    act = PrRD;
          K_IRQ:   act = {31'd0, irq};
          default: act = {31'd0, hit};
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst     = 1'b0;
    IOWrite = 1'b0;
    PrAddr  = 30'd0;
    PrWD    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: reset values and address decode
    rd(A_CTRL,   32'd0, "t1 ctrl");
    rd(A_PRESET, 32'd0, "t1 preset");
    rd(A_COUNT,  32'd0, "t1 count");
    rd(A_RSVD,   32'd0, "t1 rsvd");
    irqc(1'b0, "t1 irq");
    step();
    chk(K_HIT, 32'h0000_7EFC, 32'd0, "t1 hit 7EFC");
    chk(K_HIT, 32'h0000_7F00, 32'd1, "t1 hit 7F00");
    chk(K_HIT, 32'h0000_7F0C, 32'd1, "t1 hit 7F0C");
    step();
    chk(K_HIT, 32'h0000_7F10, 32'd0, "t1 hit 7F10");
    chk(K_HIT, 32'h0001_7F04, 32'd0, "t1 hit 17F04");
    step();

    // 2: one-shot, PRESET=5, level interrupt 9 edges after CTRL write
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    rd(A_CTRL, 32'h9, "t2 ctrl after write");
    irqc(1'b0, "t2 irq e0");
    step();
    rd(A_COUNT, 32'd0, "t2 count load");
    irqc(1'b0, "t2 irq load");
    for (int k = 0; k <= 5; k++) begin
      step();
      rd(A_COUNT, 32'(5 - k), $sformatf("t2 count k%0d", k));
      irqc(1'b0, $sformatf("t2 irq k%0d", k));
    end
    step();
    irqc(1'b0, "t2 irq int");
    step();
    irqc(1'b1, "t2 irq e9");
    rd(A_CTRL, 32'h8, "t2 ctrl en cleared");
    for (int k = 0; k < 3; k++) begin
      step();
      irqc(1'b1, $sformatf("t2 irq hold %0d", k));
    end
    wr(A_CTRL, 32'h0);
    irqc(1'b0, "t2 irq cleared");
    step();
    irqc(1'b0, "t2 irq stays low");

    // 3: auto-reload, PRESET=3, pulse every 6 cycles
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int c = 1; c <= 19; c++) begin
      step();
      rd(A_COUNT, reload_cnt(c), $sformatf("t3 count c%0d", c));
      irqc((c >= 6) && (c % 6 == 0), $sformatf("t3 irq c%0d", c));
    end
    // write lands during LOAD: load completes, then CNT exits
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, 32'd3, "t3 count after load");
    step();
    rd(A_COUNT, 32'd3, "t3 count held 1");
    irqc(1'b0, "t3 irq stopped");
    step();
    rd(A_COUNT, 32'd3, "t3 count held 2");

    // 4: one-shot PRESET=100, PRESET rewrite mid-count, stop at 40
    wr(A_PRESET, 32'd100);
    wr(A_CTRL, 32'h9);
    repeat (29) step();
    rd(A_COUNT, 32'd73, "t4 count c29");
    wr(A_PRESET, 32'd7);
    rd(A_COUNT, 32'd72, "t4 count unaffected by preset");
    rd(A_PRESET, 32'd7, "t4 preset readback");
    rd(32'h0000_7F14, 32'd0, "t4 read outside window");
    repeat (32) step();
    rd(A_COUNT, 32'd40, "t4 count c62");
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, 32'd40, "t4 count stopped");
    repeat (10) step();
    rd(A_COUNT, 32'd40, "t4 count holds");
    irqc(1'b0, "t4 irq never");

    // 5: PRESET=0 with IM=0: interrupt stays masked, PEND cleared by write
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h1);
    irqc(1'b0, "t5 irq e0");
    step();
    rd(A_COUNT, 32'd40, "t5 count in load");
    step();
    rd(A_COUNT, 32'd0, "t5 count preset zero");
    step();
    rd(A_CTRL, 32'h1, "t5 ctrl during int");
    irqc(1'b0, "t5 irq int");
    step();
    rd(A_CTRL, 32'h0, "t5 ctrl en cleared");
    irqc(1'b0, "t5 irq masked");
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h8);
    rd(A_CTRL, 32'h8, "t5 ctrl im only");
    irqc(1'b0, "t5 irq after unmask");
    step();
    irqc(1'b0, "t5 irq still low");

    // 6: reset mid-count, then ignored writes
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    repeat (5) step();
    rd(A_COUNT, 32'd7, "t6 count before reset");
    rst = 1'b0;
    step();
    rst = 1'b1;
    rd(A_CTRL,   32'd0, "t6 ctrl after reset");
    rd(A_PRESET, 32'd0, "t6 preset after reset");
    rd(A_COUNT,  32'd0, "t6 count after reset");
    irqc(1'b0, "t6 irq after reset");
    repeat (4) step();
    rd(A_COUNT, 32'd0, "t6 count idle");
    irqc(1'b0, "t6 irq idle");
    wr(A_COUNT, 32'h55);
    rd(A_COUNT, 32'd0, "t6 count write ignored");
    wr(A_RSVD, 32'hFFFF_FFFF);
    rd(A_RSVD, 32'd0, "t6 rsvd reads zero");
    wr(A_CTRL, 32'hFFFF_FFF0);
    rd(A_CTRL, 32'd0, "t6 ctrl upper bits zero");
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pr_timer.md
# pr_timer

Programmable down-counting timer peripheral on the processor's external device bus (`PrAddr`/`PrWD`/`PrRD`/`IOWrite`), directly downstream of the CPU core's MEM-stage bus port. It decodes a 16-byte window and exposes three word registers: CTRL, PRESET and COUNT. Its interrupt line feeds one bit of the core's `HWInt[7:2]`. It supports one-shot (level interrupt) and auto-reload (pulse interrupt) modes.

## Interface
- `BASE`, 32'h0000_7F00: byte base of the register window; bits [3:0] must be 0.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `PrAddr`, in, 30: word address [31:2] from the core.
- `PrWD`, in, 32: write data.
- `IOWrite`, in, 1: write strobe; sampled at the rising edge.
- `PrRD`, out, 32: read data; combinational; 0 when not hit.
- `hit`, out, 1: combinational; `PrAddr[31:4] == BASE[31:4]`.
- `irq`, out, 1: interrupt request to `HWInt`.

## Operation
- Register map, selected by `PrAddr[3:2]`:
  - 0 = CTRL, read/write.
  - 1 = PRESET, read/write, 32 bit.
  - 2 = COUNT, read-only; writes are ignored.
  - 3 = reserved; reads 0, writes ignored.
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read 0.
- PEND: internal one-shot interrupt flag, not readable.
- Write = `hit & IOWrite`, effective at that edge.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if !EN, go to IDLE and COUNT holds. Else if COUNT==0, go to INT. Else COUNT <= COUNT-1.
  - INT, MODE==1 and EN: go to LOAD (auto-reload).
  - INT, otherwise: EN <= 0, PEND <= 1, go to IDLE.
- `irq = IM & (PEND | (state==INT & MODE==1))`.
- PEND is cleared by any write to CTRL or PRESET.
- Arithmetic:
  - COUNT is 32-bit unsigned.
  - COUNT never decrements below 0; there is no wrap.
  - PRESET=0 is legal: LOAD, then CNT with COUNT=0, then INT.
- Simultaneous events:
  - A CTRL write in the same edge as the INT-state update wins for EN, MODE and IM. PEND is not set on that edge.
  - A PRESET write during CNT does not alter the running COUNT. It takes effect at the next LOAD.
  - A write clearing EN during CNT stops counting at that edge. COUNT holds and the state goes to IDLE. No interrupt is raised.
  - A write clearing EN during LOAD: LOAD completes, then CNT exits to IDLE.
- Reset (rst==0 at an edge):
  - CTRL, PRESET, COUNT and PEND go to 0; state goes to IDLE; `irq`=0.
  - Reset mid-count abandons the count with no interrupt.

## Timing
- `PrRD` and `hit` are purely combinational from `PrAddr`, so the core reads in the same cycle.
- A read returns register values as of the last edge.
- Write at edge E0 with PRESET=N, EN=1, MODE=0:
  - E1: LOAD.
  - E2: COUNT=N, state CNT.
  - E2+k: COUNT=N-k.
  - E(N+3): INT.
  - E(N+4): PEND=1; `irq` high from E(N+4) until the next CTRL/PRESET write.
- Auto-reload period is N+3 cycles: LOAD 1 + CNT N+1 + INT 1.
- In auto-reload, `irq` is a one-cycle pulse during each INT.
- Reset values:
  - `irq`=0.
  - `PrRD`=0 unless hit. While hit, reads return the reset register values.

## Structure
- Shared package `pr_dev_pkg`:
  - Register offsets: `REG_CTRL`, `REG_PRESET`, `REG_COUNT`.
  - CTRL bit positions.
  - Mode constants `MODE_ONESHOT`, `MODE_RELOAD`.
  - Timer state enum.
- Single module with no sub-modules. The address decode is a few lines and stays inline.
- Instantiated beside other bus devices. The top ORs the `PrRD` outputs, which are 0 when not hit.

## Test plan
1. Reset, then read all four offsets -> all 0; `irq`=0; `hit`=1 only for `PrAddr` in 0x7F00–0x7F0F.
2. PRESET=5, CTRL=0x9 (EN, IM, one-shot) -> COUNT reads 5,4,…,0; `irq` rises exactly 9 edges after the CTRL write; EN reads 0; `irq` stays high until CTRL is written 0, then drops.
3. PRESET=3, CTRL=0xB (auto-reload) -> `irq` one-cycle pulses every 6 cycles; COUNT sequence 3,2,1,0 repeats.
4. One-shot with PRESET=100; write CTRL=0 while COUNT=40 -> counting stops, COUNT holds 40, `irq` never asserts.
5. CTRL=0x1 (IM=0), PRESET=0 -> PEND set internally but `irq`=0. Then write PRESET -> PEND cleared; enabling IM afterwards gives no `irq`.
6. `rst` asserted mid-count with COUNT=7 -> next edge: all registers 0, state IDLE, `irq`=0. Write to offset 2 -> COUNT unchanged.
